// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: stalls register-file writes, snapshots every register
// through the async read port, then streams the snapshot over valid/ready.
module regfile_dump_reader #(
    parameter int NREGS = 4,  // power of two, >= 2
    parameter int AW    = 2,  // log2(NREGS)
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic          halt_req,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] snap [NREGS];
    logic          last_idx;
    logic          capturing;
    logic          sending;

    assign last_idx  = (idx == AW'(NREGS - 1));
    assign capturing = (state == CAPTURE);
    assign sending   = (state == SEND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            done  <= 1'b0;
            for (int i = 0; i < NREGS; i++) snap[i] <= '0;
        end else begin
            done <= 1'b0;
            // abort outranks start and the handshake, and swallows a pending done
            if (abort) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            idx   <= '0;
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        snap[idx] <= rf_data;
                        if (last_idx) begin
                            idx   <= '0;
                            state <= SEND;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    SEND: begin
                        if (out_ready) begin
                            if (last_idx) begin
                                idx   <= '0;
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs are pure decodes of registered state, zeroed outside their phase
    assign busy      = (state != IDLE);
    assign halt_req  = capturing;
    assign rf_addr   = capturing ? idx : '0;
    assign out_valid = sending;
    assign out_addr  = sending ? idx : '0;
    assign out_data  = sending ? snap[idx] : '0;
    assign out_last  = sending & last_idx;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: cycle tables, corner-case sequences and a
// randomized run scored against a queue-based transaction model.
module tb_regfile_dump_reader;
    localparam int NREGS = 4;
    localparam int AW    = 2;
    localparam int DW    = 12;

    logic          clk, reset, start, abort, out_ready;
    logic [AW-1:0] rf_addr, out_addr;
    logic [DW-1:0] rf_data, out_data;
    logic          halt_req, out_valid, out_last, busy, done;
    logic [DW-1:0] rf [NREGS];

    assign rf_data = rf[rf_addr];

    regfile_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rf_addr(rf_addr), .rf_data(rf_data), .halt_req(halt_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endfunction

    // Transaction model: remaining capture slots plus the queue of words still owed
    typedef struct { int a; logic [DW-1:0] d; } word_t;
    word_t q[$];
    int    cap    = 0;
    bit    m_done = 0;

    task automatic model_reset();
        q.delete();
        cap    = 0;
        m_done = 0;
    endtask

    task automatic model_edge(input logic s, input logic a, input logic r);
        word_t w;
        if (a) begin
            model_reset();
        end else begin
            m_done = 0;
            if (cap > 0) begin
                w.a = NREGS - cap;
                w.d = rf[NREGS - cap];
                q.push_back(w);
                cap--;
            end else if (q.size() > 0) begin
                if (r) begin
                    void'(q.pop_front());
                    if (q.size() == 0) m_done = 1;
                end
            end else if (s) begin
                cap = NREGS;
            end
        end
    endtask

    task automatic model_compare();
        bit v;
        int ea, ed;
        v  = (cap == 0) && (q.size() > 0);
        ea = 0;
        ed = 0;
        if (v) begin
            ea = q[0].a;
            ed = int'(q[0].d);
        end
        chk("busy",      32'(busy),      32'(cap > 0 || q.size() > 0));
        chk("halt_req",  32'(halt_req),  32'(cap > 0));
        chk("rf_addr",   32'(rf_addr),   (cap > 0) ? 32'(NREGS - cap) : 32'd0);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_addr",  32'(out_addr),  32'(ea));
        chk("out_data",  32'(out_data),  32'(ed));
        chk("out_last",  32'(out_last),  32'(v && q.size() == 1));
        chk("done",      32'(done),      32'(m_done));
    endtask

    // Called at a negedge: drive, settle, score, then take the rising edge
    task automatic apply(input logic s, input logic a, input logic r);
        start = s; abort = a; out_ready = r;
        #1;
        model_compare();
    endtask

    task automatic advance(input logic s, input logic a, input logic r);
        @(posedge clk);
        model_edge(s, a, r);
        @(negedge clk);
    endtask

    task automatic step(input logic s, input logic a, input logic r);
        apply(s, a, r);
        advance(s, a, r);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rf_addr"},   32'(rf_addr),   0);
        chk({tag, "_halt_req"},  32'(halt_req),  0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"},  32'(out_data),  0);
        chk({tag, "_out_addr"},  32'(out_addr),  0);
        chk({tag, "_out_last"},  32'(out_last),  0);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_done"},      32'(done),      0);
    endtask

    task automatic preload();
        rf[0] = 12'h00A; rf[1] = 12'h0B1; rf[2] = 12'h7FF; rf[3] = 12'hFFF;
    endtask

    typedef struct {
        logic          s, r, b, h, v, l, dn;
        logic [AW-1:0] rfa, a;
        logic [DW-1:0] d;
    } vec_t;

    function automatic vec_t mk(input logic s, r, b, h, input int rfa, input logic v,
                                input int a, input int d, input logic l, dn);
        vec_t t;
        t.s = s; t.r = r; t.b = b; t.h = h; t.rfa = AW'(rfa); t.v = v;
        t.a = AW'(a); t.d = DW'(d); t.l = l; t.dn = dn;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        reset = 1'b1; start = 0; abort = 0; out_ready = 0;
        for (int i = 0; i < NREGS; i++) rf[i] = '0;
        #12;
        check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic dump then backpressure 0,0,1,0,1,1,1; cycle-exact expectations
        preload();
        tbl.push_back(mk(1,1, 0,0,0, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,1, 1,1,0, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,1, 1,1,1, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,1, 1,1,2, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,1, 1,1,3, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,0,12'h00A,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,1,12'h0B1,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,2,12'h7FF,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,3,12'hFFF,1,0));
        tbl.push_back(mk(0,1, 0,0,0, 0,0,12'h000,0,1));
        tbl.push_back(mk(1,0, 0,0,0, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,0, 1,1,0, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,0, 1,1,1, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,0, 1,1,2, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,0, 1,1,3, 0,0,12'h000,0,0));
        tbl.push_back(mk(0,0, 1,0,0, 1,0,12'h00A,0,0));
        tbl.push_back(mk(0,0, 1,0,0, 1,0,12'h00A,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,0,12'h00A,0,0));
        tbl.push_back(mk(0,0, 1,0,0, 1,1,12'h0B1,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,1,12'h0B1,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,2,12'h7FF,0,0));
        tbl.push_back(mk(0,1, 1,0,0, 1,3,12'hFFF,1,0));
        tbl.push_back(mk(0,0, 0,0,0, 0,0,12'h000,0,1));
        tbl.push_back(mk(0,0, 0,0,0, 0,0,12'h000,0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s, 1'b0, tbl[i].r);
            chk("tbl_busy",      32'(busy),      32'(tbl[i].b));
            chk("tbl_halt_req",  32'(halt_req),  32'(tbl[i].h));
            chk("tbl_rf_addr",   32'(rf_addr),   32'(tbl[i].rfa));
            chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].v));
            chk("tbl_out_addr",  32'(out_addr),  32'(tbl[i].a));
            chk("tbl_out_data",  32'(out_data),  32'(tbl[i].d));
            chk("tbl_out_last",  32'(out_last),  32'(tbl[i].l));
            chk("tbl_done",      32'(done),      32'(tbl[i].dn));
            advance(tbl[i].s, 1'b0, tbl[i].r);
        end

        // Snapshot coherence: registers overwritten while the stream is stalled
        step(1, 0, 0);
        repeat (NREGS) step(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < NREGS; k++) rf[k] = 12'h555;
            step(0, 0, 0);
        end
        chk("snap_word0", 32'(out_data), 32'h00A);
        repeat (NREGS + 2) step(0, 0, 1);

        // Start during SEND is dropped; start in the done cycle is taken
        preload();
        step(1, 0, 1);
        repeat (NREGS) step(0, 0, 1);
        step(1, 0, 1);
        repeat (NREGS - 1) step(0, 0, 1);
        chk("b2b_done", 32'(done), 1);
        step(1, 0, 1);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_halt", 32'(halt_req), 1);
        repeat (2 * NREGS + 1) step(0, 0, 1);

        // Abort while word 2 is stalled
        step(1, 0, 0);
        repeat (NREGS) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("abort_pre_addr", 32'(out_addr), 2);
        step(0, 1, 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        step(1, 0, 1);
        repeat (2 * NREGS + 1) step(0, 0, 1);

        // Reset during CAPTURE, then during SEND; then dump new live values
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        #2 reset = 1'b1;
        #1 check_zero("rst_cap");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (NREGS + 2) step(0, 0, 0);
        #2 reset = 1'b1;
        #1 check_zero("rst_send");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        rf[0] = 12'h123; rf[1] = 12'h456; rf[2] = 12'h789; rf[3] = 12'hABC;
        step(0, 0, 1);
        step(1, 0, 1);
        repeat (NREGS) step(0, 0, 1);
        chk("rst_live_word0", 32'(out_data), 32'h123);
        repeat (NREGS + 1) step(0, 0, 1);

        // Randomized traffic; register writes only when no capture is under way
        for (int c = 0; c < 800; c++) begin
            if (cap == 0 && $urandom_range(3) == 0) rf[$urandom_range(NREGS - 1)] = DW'($urandom);
            step(logic'($urandom_range(7) == 0), logic'($urandom_range(39) == 0),
                 logic'($urandom_range(2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the 4-entry, 12-bit CPU register file. On a start pulse it requests a write stall from the core, reads every register through a dedicated asynchronous read port, snapshots the values into a local buffer, and then streams them out word-by-word over a valid/ready interface to the debug/trace path. The register file's write path loads architectural state; this block is the matching reader that unloads it, and it never writes to the register file.

## Interface
- NREGS, 4, number of registers read per dump; must be a power of two, at least 2.
- AW, 2, register address width; equals log2(NREGS).
- DW, 12, register data width.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clock clk.
- start  input  1  single-cycle dump request; honoured only when busy=0.
- abort  input  1  synchronous cancel; forces IDLE from any state.
- rf_addr  output  AW  read address to the register file read port.
- rf_data  input  DW  register file read data; combinational function of rf_addr.
- halt_req  output  1  asks the core to suppress RegWrite; high during CAPTURE only.
- out_valid  output  1  stream word available.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DW  snapshot value of register out_addr.
- out_addr  output  AW  index of the register in out_data.
- out_last  output  1  high with the word for register NREGS-1.
- busy  output  1  high when the state is not IDLE.
- done  output  1  one-cycle pulse after the final word is accepted.

## Operation
- States are IDLE, CAPTURE, and SEND. An AW-bit index counter idx and a buffer of NREGS×DW entries hold the walk position and the snapshot.
- In IDLE, if start=1 then idx is set to 0 and the state goes to CAPTURE. Otherwise the state holds.
- In CAPTURE, rf_addr=idx and halt_req=1. Each edge stores buf[idx] <= rf_data and increments idx. When idx==NREGS-1, the state goes to SEND and idx is set to 0. CAPTURE therefore lasts exactly NREGS cycles.
- In SEND, out_valid=1, out_data=buf[idx], out_addr=idx, and out_last=(idx==NREGS-1).
  - On out_valid && out_ready with out_last=0, idx increments.
  - On out_valid && out_ready with out_last=1, the state goes to IDLE, idx is set to 0, and done is driven high for the next cycle.
- Outside CAPTURE, rf_addr=0.
- Outside SEND, out_valid, out_data, out_addr, and out_last are all 0.
- start is ignored while busy=1. It is not queued.
- abort has priority over start and over the handshake. On abort, the next state is IDLE, idx=0, and done=0. An abort in the same cycle as the final handshake still suppresses done.
- The buffer holds its contents between dumps. Its values are only exposed during SEND.
- Index arithmetic is modulo 2^AW. No wrap occurs in practice because the terminal index forces the state transition.

## Timing
- Reset values: state=IDLE, idx=0, buffer all 0, and all outputs 0 (rf_addr=0, halt_req=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0).
- Reset asserted mid-dump aborts immediately and asynchronously to these values. No partial word is presented after reset is released.
- Let start=1 be sampled at edge E.
  - busy and halt_req go high after E.
  - Register k is captured at edge E+1+k.
  - halt_req drops and out_valid rises after edge E+NREGS.
- With out_ready held at 1, word k is accepted at edge E+NREGS+1+k and done is high in the cycle after edge E+2·NREGS. The minimum dump is 2·NREGS cycles from start to the last acceptance.
- Stall rule: while out_valid=1 && out_ready=0, out_data, out_addr, and out_last must stay stable. out_valid never drops without a handshake, except on abort or reset.
- In the done cycle, state=IDLE and busy=0. A start in that cycle is accepted and begins a new CAPTURE on the next edge.
- Every output is a registered state plus a mux of registered values. Only rf_data → buf is a combinational path from an input.

## Test plan
- Basic dump: registers 0..3 preloaded to 0x00A, 0x0B1, 0x7FF, 0xFFF, out_ready=1, start pulse at edge E.
  - Words arrive as (0,0x00A), (1,0x0B1), (2,0x7FF), (3,0xFFF), with out_last only on addr 3.
  - done pulses in the cycle after edge E+8.
  - halt_req is high for exactly 4 cycles.
- Backpressure: same preload, out_ready pattern 0,0,1,0,1,1,1.
  - Word 0 is held stable through the two stalled cycles.
  - All four words arrive in order with no duplicates and no drops.
  - done fires once.
- Snapshot coherence: after CAPTURE, overwrite registers with 0x555 while out_ready=0 for 10 cycles.
  - The streamed values are still the pre-write snapshot.
- Start while busy plus back-to-back: pulse start during SEND, which must be ignored (exactly 4 words). Then pulse start in the done cycle.
  - The second dump begins at the next edge.
- Abort: assert abort while word 2 is stalled.
  - out_valid=0 and busy=0 on the next cycle.
  - done is never asserted.
  - A following start produces a full 4-word dump.
- Reset mid-operation: assert reset during CAPTURE, and again during SEND.
  - All outputs go to 0 immediately.
  - After release, the block is in IDLE, and the first dump reads back correct live register values.
